// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pkg
// Description : Shared types and constants for the I2S transmit scheduler:
//               scheduler state encoding, underrun counter width and a
//               saturating increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  localparam int UNDERRUN_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FETCH = 2'd2
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(input logic [UNDERRUN_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage : i2s_pkg
`default_nettype wire

// File: rtl/sample_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo2
// Description : Two-entry sample FIFO. Head is always slot0. A push that
//               coincides with a pop is taken even when full, so occupancy
//               stays unchanged; flush empties the FIFO and wins over a push.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo2 #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             do_pop, do_push;

  assign empty   = (cnt_q == 2'd0);
  assign full    = (cnt_q == 2'd2);
  assign head    = slot0_q;
  assign do_pop  = pop & ~empty;
  // A full FIFO being popped frees its head slot in the same cycle.
  assign do_push = push & (~full | do_pop);

  // Next-state for storage and occupancy: shift on pop, append on push.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b01: begin
          slot0_d = slot1_q;
          cnt_d   = cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) slot0_d = push_data;
          else               slot1_d = push_data;
          cnt_d = cnt_q + 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            slot0_d = push_data;
          end else begin
            slot0_d = slot1_q;
            slot1_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : sample_fifo2
`default_nettype wire

// File: rtl/i2s_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx_scheduler
// Description : I2S transmit scheduler. Generates the bit clock and its
//               edge strobes, buffers left/right samples in 2-deep FIFOs and
//               hands alternating words to the serializer on each rising
//               edge of tx_ready, flagging and counting underruns.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx_scheduler
  import i2s_pkg::*;
#(
  parameter int NUM_BITS = 24,
  parameter int CLK_DIV  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [NUM_BITS-1:0]       l_data,
  input  logic                      l_valid,
  output logic                      l_ready,
  input  logic [NUM_BITS-1:0]       r_data,
  input  logic                      r_valid,
  output logic                      r_ready,
  input  logic                      tx_ready,
  output logic                      s_clk,
  output logic                      s_clk_pos,
  output logic                      s_clk_neg,
  output logic [NUM_BITS-1:0]       word_out,
  output logic                      chan_out,
  output logic                      underrun,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t                    state_q, state_d;
  logic [7:0]                div_q, div_d;
  logic                      sclk_q, sclk_d, pos_q, pos_d, neg_q, neg_d;
  logic                      tx_prev_q, ready_en_q;
  logic                      ch_next_q, ch_next_d;
  logic [NUM_BITS-1:0]       word_q, word_d;
  logic                      chan_q, chan_d, und_q, und_d;
  logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;

  logic                      tx_rise, fetch, flush;
  logic                      l_full, l_empty, r_full, r_empty;
  logic [NUM_BITS-1:0]       l_head, r_head;
  logic                      sel_empty;
  logic [NUM_BITS-1:0]       sel_head;

  assign tx_rise   = tx_ready & ~tx_prev_q;
  assign fetch     = (state_q == ST_FETCH);
  // Flush only on the transition into IDLE so samples can be preloaded while idle.
  assign flush     = (state_q != ST_IDLE) & ~en;
  assign sel_empty = ch_next_q ? r_empty : l_empty;
  assign sel_head  = ch_next_q ? r_head  : l_head;

  // Ready is held low until the first clock after reset release.
  assign l_ready = ready_en_q & ~l_full;
  assign r_ready = ready_en_q & ~r_full;

  sample_fifo2 #(.WIDTH(NUM_BITS)) u_fifo_l (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push(l_valid & ready_en_q), .push_data(l_data),
    .pop(fetch & ~ch_next_q), .head(l_head), .full(l_full), .empty(l_empty)
  );

  sample_fifo2 #(.WIDTH(NUM_BITS)) u_fifo_r (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push(r_valid & ready_en_q), .push_data(r_data),
    .pop(fetch & ch_next_q), .head(r_head), .full(r_full), .empty(r_empty)
  );

  // Bit-clock divider: toggle s_clk on wrap; disabling drops s_clk with no strobe.
  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    pos_d  = 1'b0;
    neg_d  = 1'b0;
    if (!en) begin
      div_d  = 8'd0;
      sclk_d = 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_d  = 8'd0;
      sclk_d = ~sclk_q;
      pos_d  = ~sclk_q;
      neg_d  = sclk_q;
    end else begin
      div_d = div_q + 8'd1;
    end
  end

  // Scheduler next state: wait for a tx_ready rising edge, fetch for one cycle.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_WAIT;
        ST_WAIT:  if (tx_rise) state_d = ST_FETCH;
        ST_FETCH: state_d = ST_WAIT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Fetch datapath: present the selected head (or zero on underrun) and alternate channel.
  always_comb begin
    word_d    = word_q;
    chan_d    = chan_q;
    und_d     = 1'b0;
    ucnt_d    = ucnt_q;
    ch_next_d = ch_next_q;
    if (state_q == ST_IDLE) begin
      ch_next_d = 1'b0;
    end else if (fetch) begin
      ch_next_d = ~ch_next_q;
      chan_d    = ch_next_q;
      if (sel_empty) begin
        word_d = '0;
        und_d  = 1'b1;
        ucnt_d = sat_inc(ucnt_q);
      end else begin
        word_d = sel_head;
      end
    end
  end

  // All scheduler registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      div_q      <= 8'd0;
      sclk_q     <= 1'b0;
      pos_q      <= 1'b0;
      neg_q      <= 1'b0;
      tx_prev_q  <= 1'b0;
      ready_en_q <= 1'b0;
      ch_next_q  <= 1'b0;
      word_q     <= '0;
      chan_q     <= 1'b0;
      und_q      <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      pos_q      <= pos_d;
      neg_q      <= neg_d;
      tx_prev_q  <= tx_ready;
      ready_en_q <= 1'b1;
      ch_next_q  <= ch_next_d;
      word_q     <= word_d;
      chan_q     <= chan_d;
      und_q      <= und_d;
      ucnt_q     <= ucnt_d;
    end
  end

  assign s_clk        = sclk_q;
  assign s_clk_pos    = pos_q;
  assign s_clk_neg    = neg_q;
  assign word_out     = word_q;
  assign chan_out     = chan_q;
  assign underrun     = und_q;
  assign underrun_cnt = ucnt_q;

endmodule : i2s_tx_scheduler
`default_nettype wire

// File: tb/tb_i2s_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_tx_scheduler
// Description : Self-checking bench for i2s_tx_scheduler. A queue-based
//               behavioural model is advanced on every clock edge and compared
//               against the DUT on every falling edge; directed sequences pin
//               the model with literal expectations, then random traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_scheduler;

  localparam int NB = 24;
  localparam int CD = 4;

  logic          clk = 1'b0;
  logic          rst_n, en, l_valid, r_valid, tx_ready;
  logic [NB-1:0] l_data, r_data;
  logic          l_ready, r_ready, s_clk, s_clk_pos, s_clk_neg, chan_out, underrun;
  logic [NB-1:0] word_out;
  logic [15:0]   underrun_cnt;

  i2s_tx_scheduler #(.NUM_BITS(NB), .CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .l_data(l_data), .l_valid(l_valid), .l_ready(l_ready),
    .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready),
    .tx_ready(tx_ready), .s_clk(s_clk), .s_clk_pos(s_clk_pos), .s_clk_neg(s_clk_neg),
    .word_out(word_out), .chan_out(chan_out), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit run   = 1'b0;

  // ---------------- behavioural model ----------------
  int            m_k;      // consecutive enabled clock edges
  bit            m_sclk, m_pos, m_neg;
  int            m_mode;   // 0 idle, 1 waiting for tx edge, 2 fetching
  bit            m_prev, m_ch, m_rdy;
  logic [NB-1:0] lq[$], rq[$];
  logic [NB-1:0] m_word;
  bit            m_chan, m_und;
  int            m_cnt;

  task automatic model_reset();
    m_k = 0; m_sclk = 0; m_pos = 0; m_neg = 0;
    m_mode = 0; m_prev = 0; m_ch = 0; m_rdy = 0;
    lq.delete(); rq.delete();
    m_word = '0; m_chan = 0; m_und = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit fetch, flush, lpop, rpop, lpush, rpush;
    if (!rst_n) begin
      model_reset();
    end else begin
      fetch = (m_mode == 2);
      flush = (m_mode != 0) && !en;
      lpop  = fetch && !m_ch && (lq.size() > 0);
      rpop  = fetch &&  m_ch && (rq.size() > 0);
      lpush = l_valid && m_rdy && ((lq.size() < 2) || lpop);
      rpush = r_valid && m_rdy && ((rq.size() < 2) || rpop);
      m_und = 0;
      if (fetch) begin
        m_chan = m_ch;
        if (lpop)      m_word = lq.pop_front();
        else if (rpop) m_word = rq.pop_front();
        else begin
          m_word = '0;
          m_und  = 1;
          if (m_cnt < 65535) m_cnt++;
        end
      end
      if (lpush) lq.push_back(l_data);
      if (rpush) rq.push_back(r_data);
      if (flush) begin lq.delete(); rq.delete(); end
      if (m_mode == 0) m_ch = 0;
      else if (fetch)  m_ch = !m_ch;
      if (!en)              m_mode = 0;
      else if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) m_mode = (tx_ready && !m_prev) ? 2 : 1;
      else                  m_mode = 1;
      m_prev = tx_ready;
      if (en) begin
        m_k++;
        m_sclk = ((m_k / CD) % 2) == 1;
        m_pos  = (m_k % CD == 0) &&  m_sclk;
        m_neg  = (m_k % CD == 0) && !m_sclk;
      end else begin
        m_k = 0; m_sclk = 0; m_pos = 0; m_neg = 0;
      end
      m_rdy = 1;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (run) begin
      cmp("s_clk",        32'(s_clk),        32'(m_sclk));
      cmp("s_clk_pos",    32'(s_clk_pos),    32'(m_pos));
      cmp("s_clk_neg",    32'(s_clk_neg),    32'(m_neg));
      cmp("strobe_excl",  32'(s_clk_pos & s_clk_neg), 32'd0);
      cmp("word_out",     32'(word_out),     32'(m_word));
      cmp("chan_out",     32'(chan_out),     32'(m_chan));
      cmp("underrun",     32'(underrun),     32'(m_und));
      cmp("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
      cmp("l_ready",      32'(l_ready),      32'(m_rdy && (lq.size() < 2)));
      cmp("r_ready",      32'(r_ready),      32'(m_rdy && (rq.size() < 2)));
    end
  end

  // One clock: model follows the edge, inputs may change 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // tx_ready high for one cycle, then one more cycle so the fetched word is visible.
  task automatic fetch_pulse();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; l_valid = 1'b0; r_valid = 1'b0; tx_ready = 1'b0;
    l_data = '0; r_data = '0;
    model_reset();
    run = 1'b1;

    // Reset state and synchronous release.
    repeat (3) tick();
    cmp("rst_l_ready", 32'(l_ready), 32'd0);
    cmp("rst_word",    32'(word_out), 32'd0);
    rst_n = 1'b1;
    cmp("rel_l_ready_pre", 32'(l_ready), 32'd0);
    tick();
    cmp("rel_l_ready", 32'(l_ready), 32'd1);
    cmp("rel_r_ready", 32'(r_ready), 32'd1);

    // Divider with CLK_DIV=4; one left sample pushed along the way.
    en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      l_valid = (i == 10);
      l_data  = 24'hABCDEF;
      tick();
      cmp("div_pos", 32'(s_clk_pos), 32'(i == 4 || i == 12 || i == 20));
      cmp("div_neg", 32'(s_clk_neg), 32'(i == 8 || i == 16));
    end
    cmp("div_sclk_hi", 32'(s_clk), 32'd1);

    // Disable while s_clk is high: drops at once, no falling strobe, FIFOs flushed.
    en = 1'b0;
    tick();
    cmp("dis_sclk", 32'(s_clk), 32'd0);
    cmp("dis_neg",  32'(s_clk_neg), 32'd0);

    // Underrun on the (flushed) left FIFO, then the right channel is selected.
    en = 1'b1;
    tick();
    fetch_pulse();
    cmp("und_word",  32'(word_out), 32'd0);
    cmp("und_pulse", 32'(underrun), 32'd1);
    cmp("und_cnt",   32'(underrun_cnt), 32'd1);
    cmp("und_chan",  32'(chan_out), 32'd0);
    tick();
    cmp("und_pulse_end", 32'(underrun), 32'd0);
    r_valid = 1'b1; r_data = 24'h222222;
    tick();
    r_valid = 1'b0;
    fetch_pulse();
    cmp("after_und_word", 32'(word_out), 32'h222222);
    cmp("after_und_chan", 32'(chan_out), 32'd1);

    // Alternation.
    l_valid = 1'b1; l_data = 24'h111111;
    r_valid = 1'b1; r_data = 24'h222222;
    tick();
    l_valid = 1'b0; r_valid = 1'b0;
    fetch_pulse();
    cmp("alt_word_l", 32'(word_out), 32'h111111);
    cmp("alt_chan_l", 32'(chan_out), 32'd0);
    fetch_pulse();
    cmp("alt_word_r", 32'(word_out), 32'h222222);
    cmp("alt_chan_r", 32'(chan_out), 32'd1);

    // Full left FIFO with push and fetch in the same cycle.
    l_valid = 1'b1; l_data = 24'h0000A1;
    tick();
    l_data = 24'h0000B2;
    tick();
    cmp("full_ready", 32'(l_ready), 32'd0);
    l_data = 24'h0000C3; tx_ready = 1'b1;
    tick();
    cmp("full_ready_wait", 32'(l_ready), 32'd0);
    tx_ready = 1'b0;
    tick();
    l_valid = 1'b0;
    cmp("full_pop_word",  32'(word_out), 32'h0000A1);
    cmp("full_pop_ready", 32'(l_ready), 32'd0);
    fetch_pulse();
    fetch_pulse();
    cmp("full_order_b", 32'(word_out), 32'h0000B2);
    fetch_pulse();
    fetch_pulse();
    cmp("full_order_c", 32'(word_out), 32'h0000C3);
    cmp("full_und_cnt", 32'(underrun_cnt), 32'd3);

    // Asynchronous reset while in FETCH.
    l_valid = 1'b1; l_data = 24'h5A5A5A;
    tick();
    l_valid = 1'b0; tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    cmp("arst_word",  32'(word_out), 32'd0);
    cmp("arst_cnt",   32'(underrun_cnt), 32'd0);
    cmp("arst_sclk",  32'({s_clk, s_clk_pos, s_clk_neg, underrun, chan_out}), 32'd0);
    cmp("arst_ready", 32'({l_ready, r_ready}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    cmp("arst_rel_ready", 32'(l_ready), 32'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      en      = ($urandom_range(0, 63) != 0);
      l_valid = ($urandom_range(0, 2) == 0);
      r_valid = ($urandom_range(0, 2) == 0);
      l_data  = 24'($urandom());
      r_data  = 24'($urandom());
      if ($urandom_range(0, 5) == 0) tx_ready = ~tx_ready;
      tick();
    end

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_i2s_tx_scheduler
`default_nettype wire

// File: doc/i2s_tx_scheduler.md
I2S_TX_SCHEDULER -- requirements
Module: i2s_tx_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 24, meaning sample width in bits.
REQ-002 The block SHALL have parameter CLK_DIV, default 8, meaning clk cycles per s_clk half-period; legal range 2..255.
REQ-003 The block SHALL have ports, clock and reset first:
- clk  in  1  system clock; the block's only clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable (level)
- l_data  in  NUM_BITS  left sample
- l_valid  in  1  left sample valid
- l_ready  out  1  left FIFO can accept
- r_data  in  NUM_BITS  right sample
- r_valid  in  1  right sample valid
- r_ready  out  1  right FIFO can accept
- tx_ready  in  1  transmitter serializer-empty level
- s_clk  out  1  bit clock to pin
- s_clk_pos  out  1  one-cycle strobe, s_clk rising
- s_clk_neg  out  1  one-cycle strobe, s_clk falling
- word_out  out  NUM_BITS  word presented to transmitter word_in
- chan_out  out  1  channel of word_out (0 = left, 1 = right)
- underrun  out  1  one-cycle pulse, fetch found selected FIFO empty
- underrun_cnt  out  16  saturating underrun count

Function
REQ-004 The block SHALL run a divider counter 0..CLK_DIV-1 while en=1; on count CLK_DIV-1 it SHALL wrap to 0 and toggle s_clk.
REQ-005 s_clk_pos (s_clk_neg) SHALL assert for exactly the one clk cycle in which the s_clk register goes 0->1 (1->0); pos and neg SHALL never assert together.
REQ-006 With en=0, the divider SHALL hold 0, s_clk SHALL hold 0, and both strobes SHALL be 0; after en rises, the first s_clk_pos SHALL occur CLK_DIV cycles later.
REQ-007 Deasserting en mid-period SHALL force s_clk low immediately, with no s_clk_neg strobe generated.
REQ-008 Each channel SHALL have a 2-entry FIFO; x_ready = not full, and a push SHALL occur when x_valid & x_ready.
REQ-009 The state machine SHALL have states IDLE, WAIT, FETCH.
- IDLE: entered when en=0.
- IDLE->WAIT: on en=1.
- WAIT->FETCH: on tx_ready rising edge (tx_ready=1 and previous-cycle tx_ready=0).
- FETCH->WAIT: after one cycle.
- Any state->IDLE: on en=0.
REQ-010 Channel selection SHALL use an internal toggle ch_next, set to 0 in IDLE and inverted on every FETCH.
REQ-011 In FETCH the block SHALL pop FIFO[ch_next] and register its head onto word_out, with chan_out = ch_next; word_out SHALL be valid 2 cycles after the tx_ready rising edge and SHALL hold until the next FETCH.
REQ-012 If FIFO[ch_next] is empty in FETCH, word_out SHALL become 0, underrun SHALL pulse, underrun_cnt SHALL increment (saturating at 0xFFFF), and ch_next SHALL still toggle.
REQ-013 A push and a pop on the same FIFO in the same cycle SHALL both occur; occupancy is unchanged, including when full.
REQ-014 Entering IDLE SHALL flush both FIFOs; word_out and underrun_cnt SHALL hold their values.

Reset
REQ-015 While rst_n=0, the outputs SHALL be:
- s_clk, s_clk_pos, s_clk_neg, underrun, chan_out: 0
- word_out: 0
- underrun_cnt: 0
- l_ready, r_ready: 0
REQ-016 While rst_n=0, the state SHALL be IDLE, both FIFOs SHALL be empty, and the divider and the tx_ready edge register SHALL be 0.
REQ-017 Reset SHALL be asserted asynchronously and released synchronously to clk; l_ready and r_ready SHALL rise on the first clk edge after release.

Structure
REQ-018 The state encoding and the UNDERRUN_CNT_W=16 constant SHALL reside in the shared package i2s_pkg.
REQ-019 The FIFO SHALL be one sub-module, sample_fifo2, instantiated once per channel.
REQ-020 All logic SHALL be clocked by clk only; s_clk SHALL be a data output and SHALL never be used as a clock.

Verification
REQ-021 Divider: CLK_DIV=4, en=1 -> s_clk period 8 clk; s_clk_pos at cycles 4, 12, 20; s_clk_neg at cycles 8, 16.
REQ-022 Alternation: preload l=0x111111 and r=0x222222, pulse tx_ready twice -> word_out/chan_out = 0x111111/0 then 0x222222/1, each 2 cycles after its edge.
REQ-023 Underrun: left FIFO empty, one tx_ready rising edge -> word_out=0, one underrun pulse, underrun_cnt=1, next fetch selects right.
REQ-024 Full and simultaneous access: left FIFO full, push and FETCH in the same cycle -> l_ready stays 0, occupancy stays 2, order preserved.
REQ-025 Disable and reset: en dropped while s_clk=1 -> s_clk=0 the next cycle, no s_clk_neg, FIFOs empty; rst_n pulsed mid-FETCH -> all REQ-015 values, and underrun_cnt=0.
